mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the VeriRISC CPU bus. It services the controller's mem_rd/mem_wr strobes against an internal word array.
- Inserts a configurable number of wait states and signals completion with mem_ready.
- Sits between the CPU address/data mux and the data path. It is the target end of the interface the CPU controller drives.

Parameters:
- DATA_WIDTH, 8, word width of data_in/data_out and the array.
- ADDR_WIDTH, 5, address width; array depth is 2**ADDR_WIDTH.
- WAIT_STATES, 1, extra cycles between request acceptance and mem_ready; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- mem_rd  input  1  read strobe from the controller, level.
- mem_wr  input  1  write strobe from the controller, level.
- addr  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data; registered.
- mem_ready  output  1  access complete; data_out valid for reads.
- access_err  output  1  one-cycle pulse: mem_rd and mem_wr both high in IDLE.
- parity_err  output  1  read parity mismatch; see Optional Feature.

Behaviour:
- Reset (async, !reset):
  - state=IDLE, data_out=0, mem_ready=0, access_err=0, parity_err=0, wait counter=0.
  - Array contents are not reset.
  - Reset mid-access aborts it; no array write occurs.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - Exactly one strobe high at edge E0: capture addr, op (rd/wr) and data_in.
    - WAIT_STATES>0: go to WAIT with cnt=WAIT_STATES-1.
    - WAIT_STATES=0: complete the access at E0 and go to HOLD.
  - Both strobes high: access_err=1 for one cycle; stay in IDLE; no access.
  - No strobe: stay in IDLE.
- WAIT:
  - Decrement cnt each edge. At the edge where cnt==0, complete the access and go to HOLD.
  - Strobe dropped, or addr/op differ from captured values: abort and return to IDLE; no write, mem_ready stays 0. The new request is evaluated from IDLE on the next edge.
  - data_in changes during WAIT are ignored; the captured value is written.
- Completion:
  - Read: data_out<=array[addr_q].
  - Write: array[addr_q]<=data_q; data_out is unchanged.
  - mem_ready<=1 on the same edge.
  - Resulting latency: mem_ready is high in the cycle following edge E0+WAIT_STATES.
- HOLD:
  - mem_ready stays 1 and data_out stays stable while the same strobe is high with unchanged addr.
  - A held write is not re-written.
  - Strobe low: mem_ready<=0, go to IDLE.
  - addr or op change while a strobe is high: mem_ready<=0, go to IDLE. The change is treated as a new request on the next edge.
- Read-after-write to the same address returns the new data. No bypass is needed, since accesses are serialized.
- data_out holds the last read value across writes and idle periods.
- Counter width: 4 bits. WAIT_STATES outside 0..15 is a static elaboration error.

Optional Feature:
- Macro: MEM_PARITY_EN.
- When defined:
  - The array stores an extra even-parity bit per word, computed from data_q at write completion.
  - On read completion the stored bit is compared with the recomputed parity of the read word.
  - A mismatch sets parity_err=1 together with mem_ready. It is held through HOLD and cleared on leaving HOLD.
  - A debug input is not added. The bench corrupts parity via hierarchical force on the parity array.
- When undefined: no parity storage; parity_err is tied to 0.

Test Plan:
- Reset, then write: WAIT_STATES=1, mem_wr=1, addr=5, data_in=8'hA5 -> mem_ready rises 2 cycles after the strobe is seen; array[5]=8'hA5. Deassert strobe -> mem_ready=0 next cycle.
- Read back: mem_rd=1, addr=5 -> mem_ready and data_out=8'hA5 after the same latency; both stable while mem_rd is held 3 cycles.
- Zero wait states: WAIT_STATES=0, write 8'h3C to addr 31, then read addr 31 -> mem_ready 1 cycle after each strobe; data_out=8'h3C; address wrap boundary exercised.
- Abort: WAIT_STATES=3; mem_wr to addr 2 with 8'hFF, drop strobe after 1 cycle -> no mem_ready; a later read of addr 2 returns its previous value (e.g. 8'h00 written earlier).
- Conflict and reset: mem_rd=mem_wr=1 in IDLE -> access_err pulse for 1 cycle, no ready. Assert reset during WAIT of a write -> all outputs 0, array unchanged.
- MEM_PARITY_EN: write 8'h01 to addr 7, force its parity bit flipped, read addr 7 -> parity_err=1 with mem_ready; without the macro, parity_err=0 throughout.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: target end of the VeriRISC controller memory interface.
// Services level mem_rd/mem_wr strobes against an internal word array,
// inserting WAIT_STATES cycles before raising mem_ready.
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per word
// and flag read parity mismatches on parity_err; otherwise parity_err is 0.
module mem_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 5,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  mem_ready,
    output logic                  access_err,
    output logic                  parity_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("mem_responder: WAIT_STATES must be within 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  op_q;     // 1 = write, 0 = read
    logic [3:0]            cnt;

    logic                  req_one;
    logic                  req_both;
    logic                  match;
    logic                  capture;
    logic                  complete;
    logic                  acc_op;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  ready_next;
    logic                  err_next;

    assign req_one  = mem_rd ^ mem_wr;
    assign req_both = mem_rd & mem_wr;
    // The live request still matches the one that was captured.
    assign match    = req_one && (mem_wr == op_q) && (addr == addr_q);
    assign rd_word  = mem[acc_addr];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, count down, abort on request change, hold.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_one) begin
                    state_next = NO_WAIT ? S_HOLD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!match) begin
                    state_next = S_IDLE;
                end else if (cnt == '0) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!match) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output/control decode; in IDLE the live inputs feed a zero-wait access.
    always_comb begin
        capture  = (state == S_IDLE) && req_one;
        complete = 1'b0;
        acc_op   = op_q;
        acc_addr = addr_q;
        acc_data = data_q;
        if (state == S_IDLE) begin
            acc_op   = mem_wr;
            acc_addr = addr;
            acc_data = data_in;
            complete = req_one && NO_WAIT;
        end else if (state == S_WAIT) begin
            complete = match && (cnt == '0);
        end
        ready_next = complete || ((state == S_HOLD) && match);
        err_next   = (state == S_IDLE) && req_both;
    end

    // Captured request, wait counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            data_q     <= '0;
            op_q       <= 1'b0;
            cnt        <= '0;
            data_out   <= '0;
            mem_ready  <= 1'b0;
            access_err <= 1'b0;
        end else begin
            mem_ready  <= ready_next;
            access_err <= err_next;
            if (capture) begin
                addr_q <= addr;
                data_q <= data_in;
                op_q   <= mem_wr;
                cnt    <= CNT_INIT;
            end else if ((state == S_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 4'd1;
            end
            if (complete && !acc_op) begin
                data_out <= rd_word;
            end
        end
    end

    // Word array write; gated by reset so an aborted access never lands.
    always_ff @(posedge clk) begin
        if (reset && complete && acc_op) begin
            mem[acc_addr] <= acc_data;
        end
    end

`ifdef MEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_bad;
    logic parity_q;

    assign par_bad    = (^rd_word) != par_mem[acc_addr];
    assign parity_err = parity_q;

    // Even-parity bit stored alongside each written word.
    always_ff @(posedge clk) begin
        if (reset && complete && acc_op) begin
            par_mem[acc_addr] <= ^acc_data;
        end
    end

    // Mismatch flag set on read completion, held through HOLD only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (complete) begin
            parity_q <= !acc_op && par_bad;
        end else begin
            parity_q <= (state == S_HOLD) && match && parity_q;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
